mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter sharing the single unified memory of the multicycle processor between the control unit's memory requests (MemRead/MemWrite with IorD-selected address) and a loader/debug port used for program download and inspection. Each transaction is serialized through a small state machine that drives the memory with a fixed read latency. While its access is outstanding, the arbiter raises a stall to the control unit so the control unit holds its current state.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles (>=1): command in cycle t, mem_rdata valid in cycle t+MEM_LAT

- Clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  control unit access request (MemRead|MemWrite)
- cpu_we  in  1  1 = write
- cpu_addr  in  ADDR_W  address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid from cpu_ack onward
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_W/DATA_W  loader request, same meaning as cpu_*
- ldr_rdata  out  DATA_W  loader read data
- ldr_ack  out  1  one-cycle completion pulse
- mem_en  out  1  one-cycle command strobe
- mem_we  out  1  write enable, only high with mem_en
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req high, pick grant, latch that requester's we/addr/wdata into mem_* registers, go to ISSUE; else stay.
- Grant: single requester wins; both high means round-robin, granting the requester not served last. last_grant resets to LDR, so CPU wins the first tie.
- ISSUE: mem_en=1, mem_we=latched we for one cycle; clear latency counter; go to WAIT.
- WAIT: count MEM_LAT cycles. On the last one, capture mem_rdata into the granted requester's rdata register (reads only; writes leave rdata unchanged). Go to RESP.
- RESP: pulse granted ack, update last_grant, go to IDLE. Requests are not sampled in RESP.
- Requester holds req until ack. Payload is latched at grant, so later changes are ignored.
- Request dropped before grant: never issued. Dropped after grant: transaction completes and ack still pulses.
- Writes complete with ack exactly like reads.

## Timing
- Request first sampled in IDLE at cycle 0:
  - mem_en in cycle 1
  - capture in cycle 1+MEM_LAT
  - ack in cycle 2+MEM_LAT
  - IDLE again in cycle 3+MEM_LAT
- Back-to-back throughput: one transaction per MEM_LAT+3 cycles.
- cpu_stall is high from cycle 0 through 1+MEM_LAT, low in the ack cycle.
- Reset values: state IDLE, last_grant LDR, mem_en/mem_we/cpu_ack/ldr_ack 0, mem_addr/mem_wdata/cpu_rdata/ldr_rdata 0.
- Reset mid-operation: all outputs go to reset values immediately (asynchronous). The transaction is abandoned and no ack follows reset release.
- cpu_stall follows cpu_req during reset.

## Structure
- Package mem_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - grant IDs GNT_CPU=0, GNT_LDR=1
- One sub-module rr_pick2: 2-way round-robin picker with inputs req[1:0] and last, output grant id plus valid.
- Latency counter is $clog2(MEM_LAT+1) bits, inline.

## Test plan
All scenarios use MEM_LAT=2 and a memory model with 2-cycle read latency.
- CPU read 0x10, memory returns 0xDEADBEEF -> mem_en/mem_addr=0x10/mem_we=0 in cycle 1; cpu_ack and cpu_rdata=0xDEADBEEF in cycle 4; cpu_stall high cycles 0-3.
- Loader write 0x20←0x12345678 -> mem_en&mem_we cycle 1 with mem_wdata=0x12345678; ldr_ack cycle 4; ldr_rdata unchanged.
- cpu_req and ldr_req rise together after reset -> CPU served first (ack cycle 4), loader ack cycle 9.
- Both requests held continuously -> grants alternate CPU, LDR, CPU, LDR, with one ack every 5 cycles.
- ldr_req pulsed for 2 cycles while CPU is in WAIT -> no loader transaction issued, no ldr_ack.
- reset asserted during WAIT -> mem_en and both acks 0 immediately, no ack after release; a subsequent CPU read of 0x10 completes normally at cycle 4.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the unified-memory arbiter
//
// Purpose: state encoding of the arbiter FSM and the requester grant IDs.
// Ports: none (package).

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arbState_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_LDR = 1'b1
  } gntId_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bundle of requester and memory signals around the arbiter
//
// Purpose: groups the control-unit port, the loader/debug port and the
//          memory command/data port into one interface.
// Modports:
//   slave  - arbiter view: takes cpu_*/ldr_* requests and mem_rdata,
//            returns rdata/ack/stall and drives the memory command.
//   master - environment view: requesters plus the memory device.

interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_rdata, ldr_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_rdata, ldr_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin picker
//
// Purpose: chooses between the CPU (req[0]) and loader (req[1]) requests.
//          A lone requester always wins; on a tie the requester that was
//          not served last wins.
// Ports:
//   req   in  2  request vector, bit 0 = CPU, bit 1 = loader
//   last  in  1  requester served by the previous transaction
//   grant out 1  chosen requester ID
//   valid out 1  at least one request present

module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  gntId_e     last,
  output gntId_e     grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = GNT_CPU;
    case (req)
      2'b01:   grant = GNT_CPU;
      2'b10:   grant = GNT_LDR;
      2'b11:   grant = (last == GNT_CPU) ? GNT_LDR : GNT_CPU;
      default: grant = GNT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serializes CPU and loader accesses onto the unified memory
//
// Purpose: one transaction at a time flows IDLE -> ISSUE -> WAIT -> RESP.
//          The winning requester's payload is latched at grant; the memory
//          sees a one-cycle command strobe and returns read data MEM_LAT
//          cycles later. The CPU is stalled until its ack.
// Ports:
//   Clock  in  system clock, rising edge
//   reset  in  asynchronous, active-high
//   bus    mem_arbiter_if.slave - cpu_*, ldr_* request ports and mem_* port

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic          Clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

  arbState_e         state;
  gntId_e            lastGrant;
  gntId_e            grantQ;
  logic              isWriteQ;
  logic [CNT_W-1:0]  latCnt;

  logic              memEnQ;
  logic              memWeQ;
  logic [ADDR_W-1:0] memAddrQ;
  logic [DATA_W-1:0] memWdataQ;
  logic [DATA_W-1:0] cpuRdataQ;
  logic [DATA_W-1:0] ldrRdataQ;
  logic              cpuAckQ;
  logic              ldrAckQ;

  gntId_e            pickGrant;
  logic              pickValid;

  rr_pick2 uPick (
    .req   ({bus.ldr_req, bus.cpu_req}),
    .last  (lastGrant),
    .grant (pickGrant),
    .valid (pickValid)
  );

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lastGrant <= GNT_LDR;
      grantQ    <= GNT_CPU;
      isWriteQ  <= 1'b0;
      latCnt    <= '0;
      memEnQ    <= 1'b0;
      memWeQ    <= 1'b0;
      memAddrQ  <= '0;
      memWdataQ <= '0;
      cpuRdataQ <= '0;
      ldrRdataQ <= '0;
      cpuAckQ   <= 1'b0;
      ldrAckQ   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pickValid) begin
            // Strobe is raised here so it is visible during the ISSUE cycle.
            grantQ <= pickGrant;
            memEnQ <= 1'b1;
            if (pickGrant == GNT_CPU) begin
              memWeQ    <= bus.cpu_we;
              isWriteQ  <= bus.cpu_we;
              memAddrQ  <= bus.cpu_addr;
              memWdataQ <= bus.cpu_wdata;
            end else begin
              memWeQ    <= bus.ldr_we;
              isWriteQ  <= bus.ldr_we;
              memAddrQ  <= bus.ldr_addr;
              memWdataQ <= bus.ldr_wdata;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          memEnQ <= 1'b0;
          memWeQ <= 1'b0;
          latCnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (latCnt == LAST_CNT) begin
            // mem_rdata is valid in this cycle; writes keep old rdata.
            if (!isWriteQ) begin
              if (grantQ == GNT_CPU) cpuRdataQ <= bus.mem_rdata;
              else                   ldrRdataQ <= bus.mem_rdata;
            end
            if (grantQ == GNT_CPU) cpuAckQ <= 1'b1;
            else                   ldrAckQ <= 1'b1;
            state <= RESP;
          end else begin
            latCnt <= latCnt + 1'b1;
          end
        end
        RESP: begin
          cpuAckQ   <= 1'b0;
          ldrAckQ   <= 1'b0;
          lastGrant <= grantQ;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = memEnQ;
  assign bus.mem_we    = memWeQ;
  assign bus.mem_addr  = memAddrQ;
  assign bus.mem_wdata = memWdataQ;
  assign bus.cpu_rdata = cpuRdataQ;
  assign bus.ldr_rdata = ldrRdataQ;
  assign bus.cpu_ack   = cpuAckQ;
  assign bus.ldr_ack   = ldrAckQ;
  // Combinational so the control unit freezes in the very cycle it asks.
  assign bus.cpu_stall = bus.cpu_req & ~cpuAckQ;

endmodule
